// File: rtl/window_sched_if.sv
// Request/window bundle between a producer and window_sched.
// Handshake: a request transfers on a posedge where req_valid && req_ready; req_ready is high
// exactly when the FIFO is not full. req_len/req_data must be stable while req_valid is high.
interface window_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_len;
  logic [15:0] req_data;
  logic [15:0] timer;
  logic [15:0] data;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [1:0]  fsm_state;

  modport master (
    output req_valid, req_len, req_data,
    input  req_ready, timer, data, busy, drop_cnt, fsm_state
  );

  modport slave (
    input  req_valid, req_len, req_data,
    output req_ready, timer, data, busy, drop_cnt, fsm_state
  );
endinterface

// File: rtl/window_sched.sv
// Queues {len, data} window requests and plays each one out as LOAD, RUN (len cycles), GAP
// towards a downstream timed state machine; zero-length requests are dropped and counted.
module window_sched #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  window_sched_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [15:0] fifo_len  [DEPTH];
  logic [15:0] fifo_data [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] head_len;
  logic [15:0] head_data;

  logic [15:0] lat_len;
  logic [15:0] lat_data;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic        latch;
  logic        drop_inc;
  logic [15:0] timer_n;
  logic [15:0] data_n;
  logic        busy_n;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FULL_CNT);
  assign empty     = (wr_ptr == rd_ptr);
  assign push      = bus.req_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head_len  = fifo_len[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];

  assign bus.req_ready = !full;
  assign bus.fsm_state = state;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_len[wr_ptr[AW-1:0]]  <= bus.req_len;
      fifo_data[wr_ptr[AW-1:0]] <= bus.req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Outputs are registered, so their next values are derived alongside the next state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    latch    = 1'b0;
    drop_inc = 1'b0;
    timer_n  = 16'd0;
    data_n   = 16'd0;
    busy_n   = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          if (head_len == 16'd0) begin
            drop_inc = 1'b1;
          end else begin
            latch   = 1'b1;
            state_n = LOAD;
            timer_n = head_len;
            busy_n  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_n = RUN;
        cnt_n   = lat_len;
        data_n  = lat_data;
        busy_n  = 1'b1;
      end
      RUN: begin
        cnt_n  = cnt - 16'd1;
        busy_n = 1'b1;
        if (cnt == 16'd1) begin
          state_n = GAP;
        end else begin
          data_n = lat_data;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      lat_len      <= 16'd0;
      lat_data     <= 16'd0;
      bus.timer    <= 16'd0;
      bus.data     <= 16'd0;
      bus.busy     <= 1'b0;
      bus.drop_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bus.timer <= timer_n;
      bus.data  <= data_n;
      bus.busy  <= busy_n;
      if (latch) begin
        lat_len  <= head_len;
        lat_data <= head_data;
      end
      if (drop_inc && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_window_sched.sv
// Bench for window_sched: a queue-based schedule model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_window_sched;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  window_sched_if bus ();

  window_sched #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  logic chk_en = 1'b0;

  // ---------------- model ----------------
  typedef struct { logic [15:0] len; logic [15:0] dat; } req_t;
  typedef struct packed { logic [15:0] t; logic [15:0] d; logic b; } out_t;

  req_t m_q[$];
  out_t tape[$];
  out_t m_out = '0;
  int   m_drop = 0;

  // One window is the output tape LOAD(len), len x RUN(data), GAP; a new head is taken only
  // after a cycle in which nothing was busy.
  always @(posedge clk) begin
    logic acc;
    req_t h;
    out_t o;
    if (reset) begin
      m_q.delete();
      tape.delete();
      m_out  = '0;
      m_drop = 0;
      chk_en = 1'b1;
    end else begin
      acc = bus.req_valid && (m_q.size() < DEPTH);
      if (tape.size() > 0) begin
        m_out = tape.pop_front();
      end else if (!m_out.b && m_q.size() > 0) begin
        h = m_q.pop_front();
        if (h.len == 16'd0) begin
          if (m_drop < 255) m_drop++;
          m_out = '0;
        end else begin
          o.t = h.len; o.d = 16'd0; o.b = 1'b1; tape.push_back(o);
          for (int i = 0; i < int'(h.len); i++) begin
            o.t = 16'd0; o.d = h.dat; o.b = 1'b1; tape.push_back(o);
          end
          o.t = 16'd0; o.d = 16'd0; o.b = 1'b1; tape.push_back(o);
          m_out = tape.pop_front();
        end
      end else begin
        m_out = '0;
      end
      if (acc) begin
        h.len = bus.req_len;
        h.dat = bus.req_data;
        m_q.push_back(h);
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [56:0] exp_q[$];

  always @(negedge clk) begin
    logic [56:0] exp_v;
    logic [56:0] act_v;
    if (chk_en) begin
      exp_v = {m_out.t, m_out.d, m_out.b, 8'(m_drop), (m_q.size() < DEPTH), 15'd0};
      exp_q.push_back(exp_v);
      act_v = {bus.timer, bus.data, bus.busy, bus.drop_cnt, bus.req_ready, 15'd0};
      exp_v = exp_q.pop_front();
      vectors++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_model @%0t: got timer=%h data=%h busy=%b drop=%0d ready=%b, want timer=%h data=%h busy=%b drop=%0d ready=%b",
                 $time, bus.timer, bus.data, bus.busy, bus.drop_cnt, bus.req_ready,
                 exp_v[56:41], exp_v[40:25], exp_v[24], exp_v[23:16], exp_v[15]);
      end
      vectors++;
      if (bus.timer != 16'd0 && bus.data != 16'd0) begin
        fails++;
        $display("FAIL timer_data_exclusive @%0t: got timer=%h data=%h, want one of them zero",
                 $time, bus.timer, bus.data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [15:0] len, input logic [15:0] dat);
    int   waited = 0;
    logic rdy;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_len   = len;
    bus.req_data  = dat;
    forever begin
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      waited++;
      if (waited > 1000) begin
        vectors++;
        fails++;
        $display("FAIL push_timeout: got req_ready=0 for %0d cycles, want acceptance", waited);
        break;
      end
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] t, input logic [15:0] d,
                            input logic b);
    @(negedge clk);
    vectors++;
    if (bus.timer !== t || bus.data !== d || bus.busy !== b) begin
      fails++;
      $display("FAIL %s: got timer=%h data=%h busy=%b, want timer=%h data=%h busy=%b",
               nm, bus.timer, bus.data, bus.busy, t, d, b);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(bus.busy === 1'b0 && m_q.size() == 0 && tape.size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        vectors++;
        fails++;
        $display("FAIL wait_idle: got busy after %0d cycles, want idle", n);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n_run;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_len   = 16'd0;
    bus.req_data  = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_val("reset_timer", 32'(bus.timer), 32'd0);
    check_val("reset_busy",  32'(bus.busy), 32'd0);
    check_val("reset_ready", 32'(bus.req_ready), 32'd1);
    check_val("reset_drop",  32'(bus.drop_cnt), 32'd0);

    // Single window len=3
    push(16'd3, 16'hA5A5);
    expect_out("single_idle_pop", 16'd0, 16'h0000, 1'b0);
    expect_out("single_load",     16'd3, 16'h0000, 1'b1);
    expect_out("single_run1",     16'd0, 16'hA5A5, 1'b1);
    expect_out("single_run2",     16'd0, 16'hA5A5, 1'b1);
    expect_out("single_run3",     16'd0, 16'hA5A5, 1'b1);
    expect_out("single_gap",      16'd0, 16'h0000, 1'b1);
    expect_out("single_after",    16'd0, 16'h0000, 1'b0);
    wait_idle(100);

    // Zero-length drop then len=2
    push(16'd0, 16'h1234);
    push(16'd2, 16'hBEEF);
    expect_out("zero_idle", 16'd0, 16'h0000, 1'b0);
    check_val("zero_drop1", 32'(bus.drop_cnt), 32'd1);
    expect_out("zero_load2", 16'd2, 16'h0000, 1'b1);
    expect_out("zero_run1",  16'd0, 16'hBEEF, 1'b1);
    expect_out("zero_run2",  16'd0, 16'hBEEF, 1'b1);
    expect_out("zero_gap",   16'd0, 16'h0000, 1'b1);
    wait_idle(100);

    // Two len=1 windows, push and pop on the same edge
    push(16'd1, 16'h0011);
    push(16'd1, 16'h0022);
    check_val("pp_ready", 32'(bus.req_ready), 32'd1);
    expect_out("pp_load_a", 16'd1, 16'h0000, 1'b1);
    expect_out("pp_run_a",  16'd0, 16'h0011, 1'b1);
    expect_out("pp_gap_a",  16'd0, 16'h0000, 1'b1);
    expect_out("pp_idle",   16'd0, 16'h0000, 1'b0);
    expect_out("pp_load_b", 16'd1, 16'h0000, 1'b1);
    expect_out("pp_run_b",  16'd0, 16'h0022, 1'b1);
    expect_out("pp_gap_b",  16'd0, 16'h0000, 1'b1);
    wait_idle(100);

    // Back-pressure: five pushes behind a long window
    push(16'd20, 16'h1000);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) push(16'(i), 16'($urandom_range(1, 16'hFFFF)));
    @(negedge clk);
    check_val("bp_ready_low", 32'(bus.req_ready), 32'd0);
    push(16'd5, 16'h2005);
    wait_idle(500);

    // Saturation of drop_cnt
    do_reset();
    for (int i = 0; i < 300; i++) push(16'd0, 16'(i));
    wait_idle(500);
    check_val("drop_saturate", 32'(bus.drop_cnt), 32'd255);

    // Reset during RUN of len=10 at count 6
    push(16'd10, 16'h00AA);
    push(16'd4,  16'h0044);
    push(16'd5,  16'h0055);
    repeat (5) @(negedge clk);
    check_val("abort_pre_data", 32'(bus.data), 32'h00AA);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_timer", 32'(bus.timer), 32'd0);
    check_val("abort_data",  32'(bus.data), 32'd0);
    check_val("abort_busy",  32'(bus.busy), 32'd0);
    check_val("abort_ready", 32'(bus.req_ready), 32'd1);
    expect_out("abort_flushed1", 16'd0, 16'h0000, 1'b0);
    expect_out("abort_flushed2", 16'd0, 16'h0000, 1'b0);

    // Maximum length window
    push(16'hFFFF, 16'h5A5A);
    n_run = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (bus.data == 16'h5A5A) n_run++;
      if (bus.busy === 1'b0 && n_run > 0) break;
    end
    check_val("max_len_run_cycles", 32'(n_run), 32'd65535);
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/window_sched.md
WINDOW_SCHED -- requirements
Module: window_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request offered this cycle.
REQ-005 SHALL have port req_ready  output  1  FIFO can accept; high iff FIFO not full.
REQ-006 SHALL have port req_len  input  16  window length in cycles, unsigned.
REQ-007 SHALL have port req_data  input  16  payload to present during the window.
REQ-008 SHALL have port timer  output  16  registered; window length to the downstream timed state machine, nonzero only in LOAD.
REQ-009 SHALL have port data  output  16  registered; payload to downstream, nonzero only in RUN.
REQ-010 SHALL have port busy  output  1  registered; high in LOAD, RUN and GAP.
REQ-011 SHALL have port drop_cnt  output  8  count of discarded zero-length requests, saturating.

Function
REQ-012 SHALL accept a request (push {req_len, req_data}) on a posedge where req_valid and req_ready are both high; no other condition pushes.
REQ-013 SHALL keep requests in FIFO order; an entry pushed on edge N is poppable by the FSM from edge N+1.
REQ-014 SHALL push and pop on the same edge when both occur; occupancy then is unchanged.
REQ-015 SHALL drive req_ready low when occupancy equals DEPTH; pops on that edge raise req_ready from the following cycle.
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, GAP.
REQ-017 IDLE: FIFO empty -> stay; head len==0 -> pop, discard, increment drop_cnt (saturates at 255), stay IDLE; head len!=0 -> pop, latch len/data, go LOAD.
REQ-018 LOAD: timer=len, data=0 for exactly one cycle; next edge go RUN with counter=len.
REQ-019 RUN: timer=0, data=latched payload; counter decrements by 1 each edge; on the edge where counter==1, go GAP; RUN lasts exactly len cycles.
REQ-020 GAP: timer=0, data=0 for exactly one cycle so downstream returns to its idle state; next edge go IDLE.
REQ-021 Window-to-window spacing: with FIFO non-empty, next LOAD begins one cycle after GAP (IDLE occupies one cycle).
REQ-022 len=0xFFFF SHALL produce 65535 RUN cycles; counter SHALL be 16 bits with no wrap-around.
REQ-023 Requests arriving while busy SHALL be queued and never alter the active window's timer, data or duration.
REQ-024 timer and data SHALL never be nonzero in the same cycle.

Reset
REQ-025 On a posedge with reset high: state=IDLE, FIFO empty, counter=0, timer=0, data=0, busy=0, drop_cnt=0; req_ready=1 from the next cycle.
REQ-026 Reset mid-window SHALL abort immediately with no GAP cycle; queued entries are lost.
REQ-027 A push coincident with reset SHALL be discarded.

Verification
REQ-028 Single request len=3, data=0xA5A5 from idle -> cycle+1 IDLE pop, then LOAD timer=3 (1 cycle), RUN data=0xA5A5 (3 cycles), GAP zeros (1 cycle), busy high for 5 cycles.
REQ-029 Push 5 requests back-to-back with DEPTH=4 while FSM busy on a long window -> req_ready low after 4th, 5th held off, all served in order afterward.
REQ-030 Request len=0 followed by len=2 -> drop_cnt=1, only the len=2 window appears, no timer pulse for the zero entry.
REQ-031 300 zero-length requests -> drop_cnt saturates at 255.
REQ-032 Reset asserted during RUN of len=10 at count 6 -> next cycle timer=0, data=0, busy=0, FIFO empty, req_ready=1.
REQ-033 Two queued windows len=1 -> sequence LOAD(1), RUN(1), GAP, IDLE, LOAD(1), RUN(1), GAP; push and pop on same edge leave occupancy unchanged.
